// File: rtl/sobel_bus_pkg.sv
// Shared definitions for the Sobel window bus initiator.
//   - bus_state_e : initiator FSM states
//   - PIX_W/WIN_W : default pixel width and packed 3x3 window width
//   - STROBE_*/RW_* : bus signal encodings
//   - pix_lsb()   : LSB position of a pixel in the packed window. Index 0 is r1c0 and
//                   sits in the MSBs; the order is r1c0,r2c0,r3c0,r1c1,r2c1,r3c1,r1c2,r2c2,r3c2.
package sobel_bus_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 9 * PIX_W;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;
  localparam logic RW_READ       = 1'b1;
  localparam logic RW_WRITE      = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StSettle,
    StRead,
    StClear,
    StOut
  } bus_state_e;

  function automatic int unsigned pix_lsb(input int unsigned idx, input int unsigned pix_w);
    return (8 - idx) * pix_w;
  endfunction

endpackage

// File: rtl/sobel_bus_master.sv
// Initiator for the Sobel window bus. Accepts one packed 3x3 window per valid/ready
// handshake, runs the strobe/rw write -> (settle) -> read -> clear sequence against the
// slave, and presents the captured result downstream with valid/ready.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   win_valid/ready/data  : upstream window stream
//   bus_wdata, bus_rdata  : window to the slave, result from the slave
//   data_strobe, bus_rw   : bus strobe (active low), 1 = read / 0 = write
//   bus_reset_n           : slave reset, stretched one cycle past reset
//   res_valid/ready/data  : downstream result stream; res_last marks end of frame
//   win_count             : results completed in the current frame
// All outputs are registered.
module sobel_bus_master #(
  parameter int unsigned PIX_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter int unsigned FRAME_WINDOWS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             win_valid,
  output logic                             win_ready,
  input  logic [9*PIX_W-1:0]               win_data,
  output logic [9*PIX_W-1:0]               bus_wdata,
  input  logic [PIX_W-1:0]                 bus_rdata,
  output logic                             data_strobe,
  output logic                             bus_rw,
  output logic                             bus_reset_n,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [PIX_W-1:0]                 res_data,
  output logic                             res_last,
  output logic [$clog2(FRAME_WINDOWS)-1:0] win_count
);
  import sobel_bus_pkg::*;

  localparam int unsigned CntW = $clog2(FRAME_WINDOWS);
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_WINDOWS - 1);
  localparam logic [3:0] SettleLoad = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  bus_state_e state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic       rst_hold_q;

  logic [9*PIX_W-1:0] wdata_d;
  logic               res_valid_d, res_last_d, win_ready_d;
  logic [PIX_W-1:0]   res_data_d;
  logic [CntW-1:0]    count_d;
  logic               strobe_d, rw_d, bus_reset_n_d;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    wdata_d     = bus_wdata;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    count_d     = win_count;

    unique case (state_q)
      StIdle: begin
        if (win_valid && win_ready) begin
          wdata_d = win_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (SETTLE_CYCLES > 0) begin
          state_d  = StSettle;
          settle_d = SettleLoad;
        end else begin
          state_d = StRead;
        end
      end
      StSettle: begin
        if (settle_q == 4'd0) begin
          state_d = StRead;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StRead: state_d = StClear;
      StClear: begin
        // Slave registered its result at the end of READ; it is stable now.
        res_data_d  = bus_rdata;
        res_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
          count_d     = (win_count == LastIdx) ? '0 : win_count + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered, so decode them from the state being entered.
    strobe_d = STROBE_IDLE;
    rw_d     = RW_READ;
    unique case (state_d)
      StWrite: begin
        strobe_d = STROBE_ACTIVE;
        rw_d     = RW_WRITE;
      end
      StRead, StClear: strobe_d = STROBE_ACTIVE;
      default: ;
    endcase

    bus_reset_n_d = ~rst_hold_q;
    win_ready_d   = (state_d == StIdle) && bus_reset_n_d;
    res_last_d    = (count_d == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      rst_hold_q  <= 1'b1;
      bus_reset_n <= 1'b0;
      win_ready   <= 1'b0;
      bus_wdata   <= '0;
      data_strobe <= STROBE_IDLE;
      bus_rw      <= RW_READ;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
      win_count   <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      rst_hold_q  <= 1'b0;
      bus_reset_n <= bus_reset_n_d;
      win_ready   <= win_ready_d;
      bus_wdata   <= wdata_d;
      data_strobe <= strobe_d;
      bus_rw      <= rw_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_last    <= res_last_d;
      win_count   <= count_d;
    end
  end

endmodule

// File: doc/sobel_bus_master.md
Name: sobel_bus_master

Overview:
Initiator side of the Sobel window bus. Accepts one 3x3 pixel window (72 bits) per valid/ready handshake from the upstream window generator. Drives the strobe/rw bus sequence that loads the window into the Sobel slave, reads back its 8-bit result, and presents that result downstream with valid/ready. Also counts windows per frame and flags the last result of each frame.

Parameters:
PIX_W, 8, pixel and result width in bits
SETTLE_CYCLES, 0, strobe-high idle cycles inserted between the write and read phases (0..15)
FRAME_WINDOWS, 16, windows per frame; sets when res_last fires and when win_count wraps

Ports:
clk  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
win_valid  in  1  upstream window valid
win_ready  out  1  block can accept a window
win_data  in  9*PIX_W  window, packed {r1c0,r2c0,r3c0,r1c1,r2c1,r3c1,r1c2,r2c2,r3c2}, MSB first
bus_wdata  out  9*PIX_W  window driven to the slave
bus_rdata  in  PIX_W  result returned by the slave
data_strobe  out  1  bus strobe, active low
bus_rw  out  1  1 = read, 0 = write
bus_reset_n  out  1  active-low reset to the slave
res_valid  out  1  result valid
res_ready  in  1  downstream accepts the result
res_data  out  PIX_W  captured Sobel result
res_last  out  1  res_data is the last window of a frame
win_count  out  $clog2(FRAME_WINDOWS)  windows completed in the current frame

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is reset. It takes priority over everything, including mid-transaction.
- Reset values:
  - state = IDLE
  - data_strobe = 1, bus_rw = 1
  - bus_wdata = 0
  - res_valid = 0, res_data = 0, res_last = 0
  - win_count = 0
  - bus_reset_n = 0
- bus_reset_n stays 0 during the reset cycle and for 1 cycle after reset deasserts, then goes to 1.
- All outputs are registered. The bus values listed per state are the values present on the wires while in that state.
- win_ready = 1 only in IDLE, and only when bus_reset_n = 1.
- States:
  - IDLE: strobe=1, rw=1. On win_valid & win_ready, latch win_data into bus_wdata and go to WRITE.
  - WRITE (1 cycle): strobe=0, rw=0. Next state is SETTLE if SETTLE_CYCLES>0, else READ.
  - SETTLE (SETTLE_CYCLES cycles): strobe=1, rw=1. A down-counter runs; at 0, go to READ.
  - READ (1 cycle): strobe=0, rw=1. The slave registers its result at the end of this cycle.
  - CLEAR (1 cycle): strobe=0, rw=1. The slave drops its internal write/read enables. At the end of this cycle, bus_rdata is captured into res_data, res_valid is set to 1, and the state moves to OUT.
  - OUT: strobe=1, rw=1. res_valid, res_data and res_last are held stable until res_ready. On res_valid & res_ready, clear res_valid and return to IDLE.
- bus_wdata holds its value from the IDLE latch until the next accept. It is never changed during WRITE through OUT.
- Latency with SETTLE_CYCLES=0: accept at edge N; res_valid is high after edge N+3. With res_ready tied 1, throughput is 1 window per 5 cycles.
- Frame counting:
  - win_count increments when a window's result handshake completes.
  - res_last = 1 while win_count == FRAME_WINDOWS-1.
  - On that result's handshake, win_count wraps to 0.
- Backpressure: if res_ready is low, OUT holds indefinitely. data_strobe stays 1, so the bus is idle.
- A reset asserted during WRITE, READ or CLEAR abandons the transaction with no res_valid. The slave is reset via bus_reset_n.
- win_valid while not in IDLE is ignored, because win_ready = 0.

Decomposition:
- Shared package sobel_bus_pkg holds:
  - the state enum IDLE/WRITE/SETTLE/READ/CLEAR/OUT
  - PIX_W
  - WIN_W = 9*PIX_W
  - STROBE_ACTIVE = 1'b0
  - RW_READ = 1'b1, RW_WRITE = 1'b0
  - the window packing order
- No sub-module: one FSM with a settle counter, a frame counter and a reset stretcher.

Test Plan:
- Basic: reset 2 cycles, then win_data=72'h01_02_03_04_05_06_07_08_09; the bench slave returns low byte+1 -> bus sees strobe 1,0,0,0,1 with rw 1,0,1,1,1; res_data=8'h0A, res_valid exactly 3 edges after accept.
- Settle: SETTLE_CYCLES=3, same window -> exactly 3 strobe-high cycles between WRITE and READ; res_valid 6 edges after accept.
- Backpressure: res_ready=0 for 10 cycles -> res_valid/res_data stable, win_ready=0, data_strobe=1 throughout; accept resumes 1 cycle after res_ready=1.
- Frame: FRAME_WINDOWS=4, stream 9 windows with res_ready=1 -> res_last high on results 4 and 8; win_count sequence 0,1,2,3,0,1,2,3,0.
- Mid-op reset: reset asserted in READ -> next cycle state IDLE, strobe=1, res_valid=0, win_count=0, bus_reset_n low for 2 cycles; next window completes normally.
- Ignore: win_valid held high with new data during READ -> bus_wdata unchanged; new window is accepted only in IDLE.
